// File: rtl/fft_pkg.sv
// Shared defaults and FSM state encoding for the FFT input/output scheduler.
package fft_pkg;

  localparam int FFT_SIZE      = 32;
  localparam int IN_WIDTH      = 12;
  localparam int OUT_WIDTH     = 16;
  localparam int LATENCY_LIMIT = 68;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DRAIN
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the channel that did not win last time is picked.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_ch
);

  logic last_ch;

  // NOTE: combinational outputs get a default before any branch so no latch is inferred.
  always_comb begin
    gnt_ch = 1'b0;
    if (req == 2'b11) gnt_ch = ~last_ch;
    else              gnt_ch = req[1];
  end

  // Reset to channel 1 so channel 0 wins the first tie.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_ch <= 1'b1;
    else if (take) last_ch <= gnt_ch;
  end

endmodule

// File: rtl/fft_sched.sv
// Schedules one frame at a time from two show-ahead requesters into a streaming FFT and
// forwards the FFT results, tagged with the owning channel, with a watchdog on FFT latency.
module fft_sched #(
  parameter int FFT_SIZE      = fft_pkg::FFT_SIZE,
  parameter int IN_WIDTH      = fft_pkg::IN_WIDTH,
  parameter int OUT_WIDTH     = fft_pkg::OUT_WIDTH,
  parameter int LATENCY_LIMIT = fft_pkg::LATENCY_LIMIT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ch0_req,
  input  logic                        ch1_req,
  output logic                        ch0_rd,
  output logic                        ch1_rd,
  input  logic signed [IN_WIDTH-1:0]  ch0_din_r,
  input  logic signed [IN_WIDTH-1:0]  ch0_din_i,
  input  logic signed [IN_WIDTH-1:0]  ch1_din_r,
  input  logic signed [IN_WIDTH-1:0]  ch1_din_i,
  output logic                        fft_in_valid,
  output logic signed [IN_WIDTH-1:0]  fft_din_r,
  output logic signed [IN_WIDTH-1:0]  fft_din_i,
  input  logic                        fft_out_valid,
  input  logic signed [OUT_WIDTH-1:0] fft_dout_r,
  input  logic signed [OUT_WIDTH-1:0] fft_dout_i,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] dout_r,
  output logic signed [OUT_WIDTH-1:0] dout_i,
  output logic                        out_ch,
  output logic                        out_last,
  output logic                        busy,
  output logic                        timeout,
  output logic                        err_sticky
);

  import fft_pkg::*;

  localparam int               SMP_W    = $clog2(FFT_SIZE);
  localparam int               LAT_W    = $clog2(LATENCY_LIMIT);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(FFT_SIZE - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY_LIMIT - 1);

  state_e           state;
  logic [SMP_W-1:0] smp_cnt;
  logic [SMP_W-1:0] out_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             cur_ch;
  logic             gnt_ch;
  logic             take;
  logic             fwd_en;

  assign take   = (state == IDLE) && (ch0_req || ch1_req);
  // Results are only meaningful while a frame is outstanding.
  assign fwd_en = fft_out_valid && ((state == WAIT) || (state == DRAIN));

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({ch1_req, ch0_req}),
    .take   (take),
    .gnt_ch (gnt_ch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_ch     <= 1'b0;
      ch0_rd     <= 1'b0;
      ch1_rd     <= 1'b0;
      smp_cnt    <= '0;
      out_cnt    <= '0;
      lat_cnt    <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      out_last <= 1'b0;
      timeout  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            state   <= LOAD;
            busy    <= 1'b1;
            cur_ch  <= gnt_ch;
            ch0_rd  <= ~gnt_ch;
            ch1_rd  <= gnt_ch;
            smp_cnt <= '0;
          end
        end
        LOAD: begin
          if (smp_cnt == SMP_LAST) begin
            state   <= WAIT;
            ch0_rd  <= 1'b0;
            ch1_rd  <= 1'b0;
            lat_cnt <= '0;
            out_cnt <= '0;
          end else begin
            smp_cnt <= smp_cnt + 1'b1;
          end
        end
        WAIT: begin
          // lat_cnt == LAT_LAST marks the LATENCY_LIMIT-th cycle after the last sample entered the FFT.
          if (fft_out_valid) begin
            state   <= DRAIN;
            out_cnt <= SMP_W'(1);
          end else if (lat_cnt == LAT_LAST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            timeout    <= 1'b1;
            err_sticky <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (fft_out_valid) begin
            if (out_cnt == SMP_LAST) begin
              state    <= IDLE;
              busy     <= 1'b0;
              out_last <= 1'b1;
              out_cnt  <= '0;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-cycle retiming of the sample stream into the FFT and of the results out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fft_in_valid <= 1'b0;
      fft_din_r    <= '0;
      fft_din_i    <= '0;
      out_valid    <= 1'b0;
      dout_r       <= '0;
      dout_i       <= '0;
      out_ch       <= 1'b0;
    end else begin
      fft_in_valid <= ch0_rd | ch1_rd;
      fft_din_r    <= ch1_rd ? ch1_din_r : (ch0_rd ? ch0_din_r : '0);
      fft_din_i    <= ch1_rd ? ch1_din_i : (ch0_rd ? ch0_din_i : '0);
      out_valid    <= fwd_en;
      dout_r       <= fwd_en ? fft_dout_r : '0;
      dout_i       <= fwd_en ? fft_dout_i : '0;
      out_ch       <= fwd_en ? cur_ch : 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_sched.sv
// Scoreboard bench for fft_sched: requester and FFT behavioural models, expected queues, negedge monitor.
module tb_fft_sched;

  typedef struct { int r; int i; } smp_t;
  typedef struct { int r; int i; int ch; int last; } res_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ch0_req = 1'b0, ch1_req = 1'b0;
  logic               ch0_rd, ch1_rd;
  logic signed [11:0] ch0_din_r = '0, ch0_din_i = '0, ch1_din_r = '0, ch1_din_i = '0;
  logic               fft_in_valid;
  logic signed [11:0] fft_din_r, fft_din_i;
  logic               fft_out_valid = 1'b0;
  logic signed [15:0] fft_dout_r = '0, fft_dout_i = '0;
  logic               out_valid;
  logic signed [15:0] dout_r, dout_i;
  logic               out_ch, out_last, busy, timeout, err_sticky;

  fft_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ch0_req       (ch0_req),
    .ch1_req       (ch1_req),
    .ch0_rd        (ch0_rd),
    .ch1_rd        (ch1_rd),
    .ch0_din_r     (ch0_din_r),
    .ch0_din_i     (ch0_din_i),
    .ch1_din_r     (ch1_din_r),
    .ch1_din_i     (ch1_din_i),
    .fft_in_valid  (fft_in_valid),
    .fft_din_r     (fft_din_r),
    .fft_din_i     (fft_din_i),
    .fft_out_valid (fft_out_valid),
    .fft_dout_r    (fft_dout_r),
    .fft_dout_i    (fft_dout_i),
    .out_valid     (out_valid),
    .dout_r        (dout_r),
    .dout_i        (dout_i),
    .out_ch        (out_ch),
    .out_last      (out_last),
    .busy          (busy),
    .timeout       (timeout),
    .err_sticky    (err_sticky)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  smp_t in_q[$];
  res_t out_q[$];
  int   tag_q[$];

  int left0 = 0, left1 = 0;
  int fft_lat = 20, fft_gap = 0;
  bit inject = 1'b0;
  bit b2b_on = 1'b0;
  int to_cnt = 0;

  function automatic int src_r(int ch, int k); return (ch != 0) ? 200 + k : k;      endfunction
  function automatic int src_i(int ch, int k); return (ch != 0) ? -300 + 2*k : -k;  endfunction
  function automatic int res_r(int tag, int k); return tag*64 + k;                  endfunction
  function automatic int res_i(int tag, int k); return -(3*k) - tag;                endfunction

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Requesters: show-ahead ramp sources, sample index advances after each consumed rd cycle.
  int idx0 = 0, idx1 = 0;
  bit prev0 = 1'b0, prev1 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      idx0 = 0; idx1 = 0; prev0 = 1'b0; prev1 = 1'b0;
    end else begin
      if (ch0_rd && !prev0 && left0 > 0) left0--;
      if (ch1_rd && !prev1 && left1 > 0) left1--;
      if (prev0 && ch0_rd) idx0++; else if (!ch0_rd) idx0 = 0;
      if (prev1 && ch1_rd) idx1++; else if (!ch1_rd) idx1 = 0;
      prev0 = ch0_rd;
      prev1 = ch1_rd;
    end
    ch0_req   = (left0 > 0);
    ch1_req   = (left1 > 0);
    ch0_din_r = 12'(src_r(0, idx0));
    ch0_din_i = 12'(src_i(0, idx0));
    ch1_din_r = 12'(src_r(1, idx1));
    ch1_din_i = 12'(src_i(1, idx1));
  end

  // FFT model: after a full input frame, emits results fft_lat cycles later, fft_gap idle cycles apart.
  int f_cnt = 0, f_wait = 0, f_k = 0, f_tag = 0;
  bit f_active = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      f_cnt = 0; f_active = 1'b0;
      fft_out_valid = 1'b0; fft_dout_r = '0; fft_dout_i = '0;
    end else begin
      fft_out_valid = 1'b0;
      if (fft_in_valid) begin
        f_cnt++;
        if (f_cnt == 32) begin
          f_cnt = 0;
          if (tag_q.size() > 0) begin
            f_tag = tag_q.pop_front();
            if (f_tag >= 0) begin f_active = 1'b1; f_wait = fft_lat; f_k = 0; end
          end
        end
      end else if (f_active) begin
        if (f_wait > 0) f_wait--;
        if (f_wait == 0) begin
          fft_out_valid = 1'b1;
          fft_dout_r    = 16'(res_r(f_tag, f_k));
          fft_dout_i    = 16'(res_i(f_tag, f_k));
          f_k++;
          f_wait = fft_gap + 1;
          if (f_k == 32) f_active = 1'b0;
        end
      end
      if (inject) begin
        fft_out_valid = 1'b1;
        fft_dout_r    = 16'sh7fff;
        fft_dout_i    = 16'sh7fff;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a sample or a result.
  int run = 0, last_in_cyc = 0, last_out_cyc = 0;
  bit prev_rd = 1'b0, prev_to = 1'b0, armed = 1'b0;
  always @(negedge clk) begin : mon
    smp_t se;
    res_t re;
    if (!rst_n) begin
      run = 0; prev_rd = 1'b0; prev_to = 1'b0; armed = 1'b0;
    end else begin
      if (ch0_rd || ch1_rd) check("rd_onehot", ch0_rd & ch1_rd, 0);
      if (prev_rd || fft_in_valid) check("in_valid_lag", fft_in_valid, prev_rd);
      if (fft_in_valid) begin
        last_in_cyc = cyc;
        run++;
        if (in_q.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL in_extra: fft_in_valid with no sample expected, din_r=%0d", fft_din_r);
        end else begin
          se = in_q.pop_front();
          check("fft_din_r", fft_din_r, se.r);
          check("fft_din_i", fft_din_i, se.i);
        end
      end else if (run > 0) begin
        check("in_run_len", run, 32);
        run = 0;
      end
      if ((ch0_rd || ch1_rd) && !prev_rd && armed && b2b_on) begin
        check("idle_gap", cyc - last_out_cyc, 1);
        armed = 1'b0;
      end
      prev_rd = ch0_rd | ch1_rd;
      if (out_valid) begin
        if (out_q.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL out_extra: out_valid with no result expected, dout_r=%0d", dout_r);
        end else begin
          re = out_q.pop_front();
          check("dout_r", dout_r, re.r);
          check("dout_i", dout_i, re.i);
          check("out_ch", out_ch, re.ch);
          check("out_last", out_last, re.last);
          check("busy_in_frame", busy, (re.last != 0) ? 0 : 1);
        end
        if (out_last) begin last_out_cyc = cyc; armed = b2b_on; end
      end else if (out_last) begin
        check("out_last_alone", out_last, 0);
      end
      if (timeout) begin
        to_cnt++;
        check("timeout_latency", cyc - last_in_cyc, 68);
        check("err_at_timeout", err_sticky, 1);
        check("busy_at_timeout", busy, 0);
      end
      if (prev_to) check("timeout_pulse", timeout, 0);
      prev_to = timeout;
    end
  end

  task automatic push_frame(input int ch, input int tag, input bit mute);
    for (int k = 0; k < 32; k++) in_q.push_back('{src_r(ch, k), src_i(ch, k)});
    tag_q.push_back(mute ? -1 : tag);
    if (!mute)
      for (int k = 0; k < 32; k++)
        out_q.push_back('{res_r(tag, k), res_i(tag, k), ch, (k == 31) ? 1 : 0});
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((in_q.size() != 0 || out_q.size() != 0 || tag_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, (n < budget) ? 1 : 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(input string name);
    int n = 0;
    while (!(ch0_rd || ch1_rd) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, ch0_rd | ch1_rd, 1);
  endtask

  task automatic check_zero();
    check("rst_ch0_rd", ch0_rd, 0);
    check("rst_ch1_rd", ch1_rd, 0);
    check("rst_fft_in_valid", fft_in_valid, 0);
    check("rst_fft_din_r", fft_din_r, 0);
    check("rst_fft_din_i", fft_din_i, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout_r", dout_r, 0);
    check("rst_dout_i", dout_i, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_err_sticky", err_sticky, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    left0 = 0;
    left1 = 0;
    #1;
    check_zero();
    in_q.delete();
    out_q.delete();
    tag_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic inject_ov(input string name);
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    @(posedge clk); #1;
    check(name, out_valid, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single channel ramp, latency 20; stray FFT valids in IDLE and LOAD are ignored.
    inject_ov("ignore_ov_idle");
    push_frame(0, 1, 1'b0);
    left0 = 1;
    wait_rd("frame_a_start");
    repeat (3) @(posedge clk);
    #1;
    inject_ov("ignore_ov_load");
    wait_done("frame_a_done", 400);

    // Round-robin after reset: ch0, ch1, ch0, ch1 with one IDLE cycle between frames.
    do_reset();
    b2b_on = 1'b1;
    push_frame(0, 2, 1'b0);
    push_frame(1, 3, 1'b0);
    push_frame(0, 4, 1'b0);
    push_frame(1, 5, 1'b0);
    left0 = 2;
    left1 = 2;
    wait_done("frame_b_done", 1200);
    b2b_on = 1'b0;

    // Silent FFT triggers the watchdog; the next request is still served.
    push_frame(0, 0, 1'b1);
    left0 = 1;
    wait_done("frame_c_timeout", 400);
    check("timeout_count", to_cnt, 1);
    check("err_sticky_set", err_sticky, 1);
    push_frame(1, 6, 1'b0);
    left1 = 1;
    wait_done("frame_c_after", 400);
    check("err_sticky_held", err_sticky, 1);

    // Results with three idle cycles between them.
    fft_gap = 3;
    push_frame(1, 7, 1'b0);
    left1 = 1;
    wait_done("frame_d_gaps", 600);
    fft_gap = 0;

    // Reset in the middle of LOAD, then a fresh frame.
    push_frame(0, 8, 1'b0);
    left0 = 1;
    wait_rd("frame_e_start");
    repeat (10) @(posedge clk);
    #1;
    check("midload_rd", ch0_rd, 1);
    #1;
    do_reset();
    push_frame(0, 9, 1'b0);
    left0 = 1;
    wait_done("frame_e_after_reset", 400);
    check("final_to_count", to_cnt, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_sched.md
FFT_SCHED -- requirements
Module: fft_sched

Interface
REQ-001 Parameter FFT_SIZE, 32, samples per frame and output bins per frame.
REQ-002 Parameter IN_WIDTH, 12, signed sample width per real/imag part.
REQ-003 Parameter OUT_WIDTH, 16, signed FFT result width per real/imag part.
REQ-004 Parameter LATENCY_LIMIT, 68, max cycles from last loaded sample to first FFT out_valid.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 ch0_req, ch1_req  in  1 each  requester holds a complete frame ready; held until its rd burst starts.
REQ-008 ch0_rd, ch1_rd  out  1 each  sample read strobe; requester presents next sample in same cycle (show-ahead).
REQ-009 ch0_din_r/_i, ch1_din_r/_i  in  IN_WIDTH each  signed requester sample.
REQ-010 fft_in_valid  out  1  drives FFT in_valid.
REQ-011 fft_din_r, fft_din_i  out  IN_WIDTH  drives FFT din.
REQ-012 fft_out_valid  in  1  FFT out_valid.
REQ-013 fft_dout_r, fft_dout_i  in  OUT_WIDTH  FFT results.
REQ-014 out_valid  out  1  forwarded result valid.
REQ-015 dout_r, dout_i  out  OUT_WIDTH  forwarded results.
REQ-016 out_ch  out  1  channel owning the current result.
REQ-017 out_last  out  1  high with the FFT_SIZE-th result of a frame.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 timeout  out  1  one-cycle pulse on watchdog expiry; err_sticky  out  1  latched until reset.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, WAIT, DRAIN; one frame in flight at a time.
REQ-021 IDLE->LOAD when any req high; grant SHALL be round-robin: if both request, grant channel != last_ch; else the sole requester; last_ch updates on grant.
REQ-022 LOAD SHALL assert granted chN_rd for exactly FFT_SIZE consecutive cycles, other rd low; 5-bit sample counter 0..31.
REQ-023 fft_in_valid/fft_din SHALL be the registered rd/din (one-cycle latency), so fft_in_valid is high for exactly FFT_SIZE contiguous cycles.
REQ-024 LOAD->WAIT after the 32nd rd cycle; latency counter cleared.
REQ-025 WAIT: counter increments each cycle; first fft_out_valid -> DRAIN; counter reaching LATENCY_LIMIT without fft_out_valid -> timeout pulse, err_sticky=1, -> IDLE.
REQ-026 out_valid/dout SHALL be fft_out_valid/fft_dout registered once (1-cycle latency), out_ch = granted channel, during WAIT/DRAIN only.
REQ-027 Output counter SHALL count fft_out_valid cycles (gaps allowed); out_last with count 31; after it FSM -> IDLE same edge.
REQ-028 fft_out_valid in IDLE or LOAD SHALL be ignored (not forwarded, not counted).
REQ-029 A req dropping during LOAD SHALL not abort the burst; new reqs during LOAD/WAIT/DRAIN wait for IDLE.
REQ-030 Back-to-back: IDLE SHALL last exactly one cycle before the next grant.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, all outputs 0, counters 0, err_sticky 0, last_ch=1 (ch0 wins first tie).
REQ-032 Reset mid-LOAD/WAIT/DRAIN SHALL abandon the frame; no out_last emitted.

Structure
REQ-033 Package fft_pkg SHALL hold FFT_SIZE, IN_WIDTH, OUT_WIDTH, LATENCY_LIMIT defaults and the state enum.
REQ-034 One sub-module rr_arb2 (2-way round-robin with last-grant register) SHALL implement REQ-021.

Verification
REQ-035 ch0 only, ramp 0..31, FFT model latency 20 -> fft_in_valid 32 contiguous cycles one cycle after ch0_rd, 32 out_valid with out_ch=0, out_last on 32nd.
REQ-036 ch0 and ch1 both requesting after reset -> ch0 served first, then ch1 after exactly one IDLE cycle; third frame goes to ch0 if both still request.
REQ-037 FFT model never asserts out_valid -> timeout pulse 68 cycles after last loaded sample, err_sticky=1, busy=0, next request accepted.
REQ-038 FFT model outputs with 3-cycle gaps -> all 32 forwarded, out_last on 32nd only, no early return to IDLE.
REQ-039 rst_n asserted at sample 10 of LOAD -> all outputs 0 asynchronously; after release, fresh request produces a full correct frame.
